// File: rtl/uart_tx_engine_pkg.sv
// rtl/uart_tx_engine_pkg.sv - shared constants, state encoding and frame helpers for the UART transmitter
package uart_tx_engine_pkg;

   localparam int BAUD_W     = 19;
   localparam int FRAME_BITS = 11;
   localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } tx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic calc_parity(input logic [7:0] data, input logic eight,
                                        input logic sense);
      logic even;
      even = ^{data[7] & eight, data[6:0]};
      return (sense == PAR_ODD) ? ~even : even;
   endfunction

   // Unused slots between the data/parity bits and the stop bit are padded with stop-level 1s.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data, input logic eight,
                                                         input logic pen, input logic ohel);
      logic par;
      logic b8;
      logic b9;
      par = calc_parity(data, eight, ohel);
      b8  = eight ? data[7] : (pen ? par : 1'b1);
      b9  = (eight && pen) ? par : 1'b1;
      return {1'b1, b9, b8, data[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// rtl/uart_tx_engine_if.sv - write-side handshake, frame format and serial line of the UART transmitter
interface uart_tx_engine_if
   import uart_tx_engine_pkg::*;
;
   logic [BAUD_W-1:0] baud;
   logic              eight;
   logic              pen;
   logic              ohel;
   logic              load;
   logic [7:0]        data_in;
   logic              tx;
   logic              tx_rdy;

   modport master (
      output baud, eight, pen, ohel, load, data_in,
      input  tx, tx_rdy
   );

   modport slave (
      input  baud, eight, pen, ohel, load, data_in,
      output tx, tx_rdy
   );

endinterface

// File: rtl/uart_tx_engine_baud_tick_gen.sv
// rtl/uart_tx_engine_baud_tick_gen.sv - bit timer emitting one tick every baud clk cycles
module baud_tick_gen
   import uart_tx_engine_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [BAUD_W-1:0] baud,
   output logic              tick
);

   logic [BAUD_W-1:0] count_q;
   logic [BAUD_W-1:0] count_d;

   // >= rather than == so a lowered baud mid-bit cannot let the count run past it.
   assign tick = enable && (baud != '0) && (count_q >= (baud - BAUD_W'(1)));

   always_comb begin
      count_d = count_q;
      if (!enable) begin
         count_d = '0;
      end else if (baud == '0) begin
         count_d = count_q;
      end else if (tick) begin
         count_d = '0;
      end else begin
         count_d = count_q + BAUD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: loads one byte and shifts an 11-bit-time frame onto tx
module uart_tx_engine
   import uart_tx_engine_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   uart_tx_engine_if.slave  bus
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

   tx_state_e             state_q;
   logic [BIT_CNT_W-1:0]  bit_cnt_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic                  tx_q;
   logic                  rdy_q;
   logic                  tick;
   logic                  load_ok;
   logic [FRAME_BITS-1:0] load_frame;

   assign load_ok    = bus.load && (bus.baud != '0);
   assign load_frame = build_frame(bus.data_in, bus.eight, bus.pen, bus.ohel);

   baud_tick_gen u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (state_q == ST_SHIFT),
      .baud   (bus.baud),
      .tick   (tick)
   );

   // Bit 0 goes straight to tx_q at load; shift_q holds the bits still to come.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '1;
         tx_q      <= 1'b1;
         rdy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_ok) begin
                  state_q   <= ST_SHIFT;
                  bit_cnt_q <= '0;
                  tx_q      <= load_frame[0];
                  shift_q   <= {1'b1, load_frame[FRAME_BITS-1:1]};
                  rdy_q     <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (tick) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q   <= ST_IDLE;
                     bit_cnt_q <= '0;
                     tx_q      <= 1'b1;
                     rdy_q     <= 1'b1;
                  end else begin
                     tx_q      <= shift_q[0];
                     shift_q   <= {1'b1, shift_q[FRAME_BITS-1:1]};
                     bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.tx     = tx_q;
   assign bus.tx_rdy = rdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed self-checking bench for uart_tx_engine
module tb_uart_tx_engine;
   import uart_tx_engine_pkg::*;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   uart_tx_engine_if u_if ();

   uart_tx_engine dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed {tx,tx_rdy}=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Loads a byte, then checks tx/tx_rdy every cycle of the 11*b-cycle frame and the first idle cycle.
   // busy_idx >= 0 pulses load (with inverted data) at that cycle of the frame.
   task automatic send_frame(input string tag, input logic [7:0] d, input logic e, input logic p,
                             input logic o, input int b, input logic [10:0] exp, input int busy_idx);
      u_if.baud    = BAUD_W'(b);
      u_if.eight   = e;
      u_if.pen     = p;
      u_if.ohel    = o;
      u_if.data_in = d;
      u_if.load    = 1'b1;
      step();
      u_if.load = 1'b0;
      for (int c = 0; c < 11 * b; c++) begin
         chk(tag, {u_if.tx, u_if.tx_rdy}, {exp[c / b], 1'b0});
         u_if.load = (c == busy_idx);
         if (c == busy_idx) u_if.data_in = ~d;
         step();
      end
      u_if.load = 1'b0;
      chk({tag, "_end"}, {u_if.tx, u_if.tx_rdy}, 2'b11);
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      reset        = 1'b1;
      u_if.baud    = BAUD_W'(10);
      u_if.eight   = 1'b1;
      u_if.pen     = 1'b0;
      u_if.ohel    = 1'b0;
      u_if.load    = 1'b1;
      u_if.data_in = 8'h00;

      // Reset for two cycles with a load pending: load must be dropped.
      step();
      chk("reset_c1", {u_if.tx, u_if.tx_rdy}, 2'b11);
      step();
      chk("reset_c2", {u_if.tx, u_if.tx_rdy}, 2'b11);
      reset     = 1'b0;
      u_if.load = 1'b0;
      step();
      chk("post_reset_idle", {u_if.tx, u_if.tx_rdy}, 2'b11);
      step();

      // 8N1 0xA5 at baud 10.
      send_frame("8n1_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 10, 11'b11101001010, -1);
      step();

      // 8-bit parity, 0x03 at baud 4; even then odd, back to back from the first ready cycle.
      send_frame("8e1_03", 8'h03, 1'b1, 1'b1, PAR_EVEN, 4, 11'b10000000110, -1);
      send_frame("8o1_03", 8'h03, 1'b1, 1'b1, PAR_ODD, 4, 11'b11000000110, -1);
      step();

      // 7-bit odd parity, data_in[7] ignored.
      send_frame("7o1_81", 8'h81, 1'b0, 1'b1, PAR_ODD, 4, 11'b11000000010, -1);
      step();

      // Load while busy (during bit 3) must not disturb the frame.
      send_frame("busy_load", 8'hA5, 1'b1, 1'b0, 1'b0, 4, 11'b11101001010, 13);
      step();
      chk("busy_load_no_restart", {u_if.tx, u_if.tx_rdy}, 2'b11);

      // Load with baud = 0 is ignored.
      u_if.baud    = '0;
      u_if.data_in = 8'h00;
      u_if.load    = 1'b1;
      step();
      u_if.load = 1'b0;
      chk("baud0_load_c1", {u_if.tx, u_if.tx_rdy}, 2'b11);
      step();
      chk("baud0_load_c2", {u_if.tx, u_if.tx_rdy}, 2'b11);

      // Mid-frame reset during bit 5, then a clean full frame.
      u_if.baud    = BAUD_W'(4);
      u_if.eight   = 1'b1;
      u_if.pen     = 1'b0;
      u_if.data_in = 8'hA5;
      u_if.load    = 1'b1;
      step();
      u_if.load = 1'b0;
      begin
         logic [10:0] a5_frame;
         a5_frame = 11'b11101001010;
         for (int c = 0; c < 22; c++) begin
            chk("midreset_pre", {u_if.tx, u_if.tx_rdy}, {a5_frame[c / 4], 1'b0});
            step();
         end
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midreset_idle", {u_if.tx, u_if.tx_rdy}, 2'b11);
      step();
      chk("midreset_idle2", {u_if.tx, u_if.tx_rdy}, 2'b11);
      send_frame("after_reset", 8'h03, 1'b1, 1'b1, PAR_ODD, 4, 11'b11000000110, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
